// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit synchronous memory port between
// instruction fetch and data load/store. One access is in flight at a time;
// each access walks IDLE -> ISSUE -> WAIT -> RESP and the response is routed
// back to the requester that owns it.
//
// Optional feature macro: ARB_RR_EN
//   undefined (default): data always beats fetch when both are pending.
//   defined: a last-winner register alternates the winner under contention.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [7:0]        d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic [63:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic        own_data;
    logic        cmd_we;
    logic        cmd_addr2;
    logic [3:0]  lat_cnt;
    logic        data_wins;

`ifdef ARB_RR_EN
    logic        last_data;

    // Under contention the requester that did not win last time gets the port;
    // a lone requester always wins.
    always_comb begin
        data_wins = d_req & (~if_req | ~last_data);
    end
`else
    // Data has fixed priority; fetch only wins when no data request is pending.
    always_comb begin
        data_wins = d_req;
    end
`endif

    // Grants are combinational and can only happen while the port is idle.
    always_comb begin
        d_gnt  = (state == IDLE) & d_req & data_wins;
        if_gnt = (state == IDLE) & if_req & ~data_wins;
        busy   = (state != IDLE);
    end

    // Single FSM: captures the winning command, drives the memory strobe for one
    // cycle, counts out the read latency, then pulses the owner's rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own_data  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr2 <= 1'b0;
            lat_cnt   <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 64'd0;
            mem_wmask <= 8'd0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 64'd0;
`ifdef ARB_RR_EN
            last_data <= 1'b0;
`endif
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 64'd0;
            mem_wmask <= 8'd0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt || if_gnt) begin
                        own_data  <= d_gnt;
                        cmd_we    <= d_gnt & d_we;
                        cmd_addr2 <= d_gnt ? d_addr[2] : if_addr[2];
                        mem_en    <= 1'b1;
                        mem_we    <= d_gnt & d_we;
                        mem_addr  <= d_gnt ? d_addr : if_addr;
                        mem_wdata <= (d_gnt & d_we) ? d_wdata : 64'd0;
                        mem_wmask <= (d_gnt & d_we) ? d_wmask : 8'd0;
`ifdef ARB_RR_EN
                        last_data <= d_gnt;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= 4'(MEM_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        if (!own_data) begin
                            if_rdata  <= cmd_addr2 ? mem_rdata[63:32] : mem_rdata[31:0];
                            if_rvalid <= 1'b1;
                        end else begin
                            if (!cmd_we) begin
                                d_rdata <= mem_rdata;
                            end
                            d_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with
// MEM_LAT = 2 and a small latency-accurate memory model. Contention ordering
// follows ARB_RR_EN when the macro is defined.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_A5A5_5A5A;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        busy;

    logic [63:0] mem_val;
    logic [63:0] pipe1, pipe2;
    logic        vld1, vld2;
    logic [31:0] exp_if_rd;
    logic [63:0] exp_d_rd;
    int          tests_run;
    int          tests_failed;

    mem_port_arbiter #(.ADDR_W(64), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: data requested in the mem_en cycle appears LAT cycles later
    // for exactly one cycle; every other cycle returns junk.
    always @(posedge clk) begin
        pipe1 <= mem_val;
        vld1  <= mem_en;
        pipe2 <= pipe1;
        vld2  <= vld1;
    end
    assign mem_rdata = vld2 ? pipe2 : JUNK;

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [63:0] ia, input logic dr,
                                 input logic dwe, input logic [63:0] da,
                                 input logic [63:0] dwd, input logic [7:0] dwm);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_wmask = dwm;
    endtask

    task automatic cycleStep();
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction starting in the grant cycle (inputs already set)
    // and checks every cycle through RESP; returns at the following idle cycle.
    task automatic runTxn(input bit own_d, input bit drop, input bit we,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, input logic [63:0] rdval);
        mem_val = rdval;
        #1;
        checkOutput("grant_if_gnt", if_gnt, !own_d);
        checkOutput("grant_d_gnt", d_gnt, own_d);
        checkOutput("grant_busy", busy, 1'b0);
        cycleStep();
        if (drop) begin
            if (own_d) d_req = 1'b0;
            else       if_req = 1'b0;
        end
        #1;
        checkOutput("issue_mem_en", mem_en, 1'b1);
        checkOutput("issue_mem_we", mem_we, we);
        checkOutput("issue_mem_addr", mem_addr, addr);
        checkOutput("issue_mem_wmask", mem_wmask, we ? wmask : 8'h00);
        if (we) checkOutput("issue_mem_wdata", mem_wdata, wdata);
        checkOutput("issue_gnt", {if_gnt, d_gnt}, 2'b00);
        checkOutput("issue_busy", busy, 1'b1);
        for (int c = 2; c <= LAT + 1; c++) begin
            cycleStep();
            checkOutput("wait_mem_en", mem_en, 1'b0);
            checkOutput("wait_mem_cmd", {mem_we, mem_wmask}, 9'd0);
            checkOutput("wait_mem_addr", mem_addr, 64'd0);
            checkOutput("wait_rvalid", {if_rvalid, d_rvalid}, 2'b00);
            checkOutput("wait_gnt", {if_gnt, d_gnt}, 2'b00);
            checkOutput("wait_if_rdata", if_rdata, exp_if_rd);
            checkOutput("wait_d_rdata", d_rdata, exp_d_rd);
        end
        if (!own_d)  exp_if_rd = addr[2] ? rdval[63:32] : rdval[31:0];
        else if (!we) exp_d_rd = rdval;
        cycleStep();
        checkOutput("resp_if_rvalid", if_rvalid, !own_d);
        checkOutput("resp_d_rvalid", d_rvalid, own_d);
        checkOutput("resp_if_rdata", if_rdata, exp_if_rd);
        checkOutput("resp_d_rdata", d_rdata, exp_d_rd);
        checkOutput("resp_busy", busy, 1'b1);
        checkOutput("resp_gnt", {if_gnt, d_gnt}, 2'b00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mem_val      = 64'd0;
        exp_if_rd    = 32'd0;
        exp_d_rd     = 64'd0;

        // 1: two reset cycles with random inputs, then everything must be zero
        rst = 1'b1;
        applyStimulus($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        cycleStep();
        applyStimulus($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
        cycleStep();
        rst = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_mem_en_we", {mem_en, mem_we}, 2'b00);
        checkOutput("rst_mem_addr", mem_addr, 64'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
        checkOutput("rst_mem_wmask", mem_wmask, 8'd0);
        checkOutput("rst_rvalid", {if_rvalid, d_rvalid}, 2'b00);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 64'd0);
        checkOutput("rst_gnt", {if_gnt, d_gnt}, 2'b00);
        cycleStep();

        // 2: fetch of 0x104 picks the upper word
        applyStimulus(1'b1, 64'h104, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        runTxn(1'b0, 1'b1, 1'b0, 64'h104, 64'd0, 8'd0, 64'hDEADBEEF_00000013);
        checkOutput("t2_if_rdata_value", if_rdata, 32'hDEADBEEF);
        checkOutput("t2_if_rdata_held", if_rdata, exp_if_rd);

        // 3: simultaneous store and fetch, data goes first, fetch right after
        applyStimulus(1'b1, 64'h300, 1'b1, 1'b1, 64'h200, 64'h1122334455667788, 8'h0F);
        runTxn(1'b1, 1'b1, 1'b1, 64'h200, 64'h1122334455667788, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        runTxn(1'b0, 1'b1, 1'b0, 64'h300, 64'd0, 8'd0, 64'h13579BDF_2468ACE0);
        checkOutput("t3_if_rdata_value", if_rdata, 32'h2468ACE0);

        // 4: both requesters held across four transactions
        applyStimulus(1'b1, 64'h10C, 1'b1, 1'b0, 64'h400, 64'd0, 8'h00);
`ifdef ARB_RR_EN
        runTxn(1'b1, 1'b0, 1'b0, 64'h400, 64'd0, 8'h00, 64'h1111_2222_3333_4444);
        runTxn(1'b0, 1'b0, 1'b0, 64'h10C, 64'd0, 8'h00, 64'h0BADF00D_CAFEF00D);
        runTxn(1'b1, 1'b0, 1'b0, 64'h400, 64'd0, 8'h00, 64'h5555_6666_7777_8888);
        runTxn(1'b0, 1'b0, 1'b0, 64'h10C, 64'd0, 8'h00, 64'h9999AAAA_BBBBCCCC);
        checkOutput("t4_if_rdata_value", if_rdata, 32'h9999AAAA);
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
`else
        runTxn(1'b1, 1'b0, 1'b0, 64'h400, 64'd0, 8'h00, 64'h1111_2222_3333_4444);
        runTxn(1'b1, 1'b0, 1'b0, 64'h400, 64'd0, 8'h00, 64'h5555_6666_7777_8888);
        runTxn(1'b1, 1'b0, 1'b0, 64'h400, 64'd0, 8'h00, 64'h0BADF00D_CAFEF00D);
        d_req = 1'b0;
        runTxn(1'b0, 1'b1, 1'b0, 64'h10C, 64'd0, 8'h00, 64'h9999AAAA_BBBBCCCC);
        checkOutput("t4_if_rdata_value", if_rdata, 32'h9999AAAA);
`endif

        // 5: load with a full mask still issues as a read
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 64'h408, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF);
        runTxn(1'b1, 1'b1, 1'b0, 64'h408, 64'd0, 8'hFF, 64'h0123456789ABCDEF);
        checkOutput("t5_d_rdata_value", d_rdata, 64'h0123456789ABCDEF);

        // 6: reset during WAIT abandons the access, then a fetch runs normally
        applyStimulus(1'b1, 64'h104, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        mem_val = 64'h7777_7777_8888_8888;
        #1;
        checkOutput("t6_if_gnt", if_gnt, 1'b1);
        cycleStep();
        if_req = 1'b0;
        cycleStep();
        rst = 1'b1;
        #1;
        checkOutput("t6_busy_in_wait", busy, 1'b1);
        cycleStep();
        rst = 1'b0;
        #1;
        checkOutput("t6_busy_after_rst", busy, 1'b0);
        checkOutput("t6_mem_en_after_rst", mem_en, 1'b0);
        checkOutput("t6_rvalid_after_rst", {if_rvalid, d_rvalid}, 2'b00);
        checkOutput("t6_if_rdata_cleared", if_rdata, 32'd0);
        cycleStep();
        checkOutput("t6_no_late_rvalid", {if_rvalid, d_rvalid}, 2'b00);
        checkOutput("t6_still_idle", busy, 1'b0);
        exp_if_rd = 32'd0;
        exp_d_rd  = 64'd0;
        applyStimulus(1'b1, 64'h200, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
        runTxn(1'b0, 1'b1, 1'b0, 64'h200, 64'd0, 8'd0, 64'h11112222_33334444);
        checkOutput("t6_if_rdata_value", if_rdata, 32'h33334444);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 64-bit synchronous memory port between instruction fetch and data load/store. Requests are granted one at a time. The block sequences each access through a small FSM and returns the response to the requester that owns it. It sits between fetch logic, the load/store path (driven by sd/wmask decode) and the unified memory.

Parameters:
ADDR_W, 64, width of all address buses
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held high until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch request accepted (combinational pulse)
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request; held high until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  64  store data
d_wmask  in  8  byte-enable mask for stores
d_gnt  out  1  data request accepted (combinational pulse)
d_rvalid  out  1  one-cycle pulse; load data valid or store complete
d_rdata  out  64  load data
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  64  memory write data
mem_wmask  out  8  memory byte enables
mem_rdata  in  64  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: single clock domain (clk); synchronous active-high reset (rst).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state goes to IDLE. All outputs are 0, including the if_rdata/d_rdata registers and the latency counter.
- IDLE:
  - Grant is combinational: x_gnt = (state == IDLE) & x_req & winner.
  - On a grant, register the owner, address, we, wdata and wmask, then go to ISSUE.
  - No grant ever occurs outside IDLE. Requests seen in ISSUE/WAIT/RESP stay pending.
- ISSUE (one cycle):
  - mem_en = 1, driven from the registered command.
  - Fetch: mem_we = 0, mem_wmask = 0.
  - Load: mem_we = 0, mem_wmask = 0; d_wmask is ignored.
  - Store: mem_we = 1, mem_wmask = captured d_wmask.
  - mem_addr is the captured address, unmodified. Load the counter with MEM_LAT, then go to WAIT.
- WAIT (MEM_LAT cycles): decrement the counter each cycle. When the counter equals 1:
  - fetch: register if_rdata = captured addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  - load: register d_rdata = mem_rdata;
  - store: leave the data registers unchanged;
  - then go to RESP.
- RESP (one cycle): pulse the owner's x_rvalid, then return to IDLE.
- Timing: grant in cycle 0 → mem_en in cycle 1 → rvalid in cycle MEM_LAT+2 → next grant possible at cycle MEM_LAT+3. Only one transaction is ever outstanding.
- Outside ISSUE, all mem_* outputs are 0.
- Arbitration (default): when both requesters are pending, data always wins. Fetch can starve under continuous data requests; this is accepted because the core stalls fetch during load/store.
- rst in any state: IDLE on the next cycle. The in-flight access is abandoned, no rvalid is issued, and busy falls.
- if_rdata/d_rdata hold their last value between responses.

Optional Feature:
ARB_RR_EN
- Defined: a one-bit last-winner register (reset to fetch) enables round-robin arbitration. When both requesters are pending, the one that did not win the previous grant wins. A single pending requester always wins immediately.
- Undefined: fixed data-over-fetch priority; no last-winner register exists.

Test Plan:
1. Assert rst for 2 cycles with random inputs → every output is 0 and busy = 0 on the cycle after reset.
2. MEM_LAT = 2; if_req with if_addr = 0x104; memory returns 0xDEADBEEF_00000013 → if_gnt in cycle 0, mem_en/mem_addr = 0x104 in cycle 1, if_rvalid in cycle 4 with if_rdata = 0xDEADBEEF.
3. Macro off; if_req and d_req (store, d_addr = 0x200, d_wmask = 0x0F) asserted in the same cycle → d_gnt first, mem_we = 1, mem_wmask = 0x0F; if_gnt at cycle MEM_LAT+3.
4. Macro on; both requesters held high for 4 transactions → grant order D, I, D, I.
5. Load with d_wmask = 0xFF, memory returns 0x0123456789ABCDEF → mem_wmask = 0, mem_we = 0, d_rdata = 0x0123456789ABCDEF.
6. rst asserted in WAIT → IDLE next cycle with no rvalid; a subsequent fetch completes with normal timing.
